// File: rtl/tag_dispatch_scheduler.sv
// Round-robin dispatcher of {iface, tag} forwarding decisions to the packet storage read port.
// Only tags whose packet is fully written (presence bitmap) are issued; others are dropped and counted.
module tag_dispatch_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int IFACE_W = 2,
  parameter int CNT_W   = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 wr_done,
  input  logic [TAG_W-1:0]                     wr_tag,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*(IFACE_W+TAG_W)-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [2**IFACE_W-1:0]                iface_ready,
  output logic [IFACE_W+TAG_W-1:0]             tagstream_data,
  output logic                                 tagstream_valid,
  input  logic                                 tagstream_ready,
  output logic [CNT_W-1:0]                     drop_count,
  output logic                                 overwrite_err
);
  localparam int REQ_W = IFACE_W + TAG_W;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 2**TAG_W;

  logic [REQ_W-1:0]   vld_data_q, vld_data_d;
  logic               vld_q, vld_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [DEPTH-1:0]   present_q, present_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               err_q, err_d;

  logic [REQ_W-1:0]   req_arr [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   gnt_next;
  logic               found;
  logic               out_free;
  logic [REQ_W-1:0]   sel;
  logic [TAG_W-1:0]   sel_tag;
  logic               issue;
  logic               drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign out_free = !vld_q || tagstream_ready;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_arr[i]  = req_data[i*REQ_W +: REQ_W];
      eligible[i] = req_valid[i] && iface_ready[req_arr[i][REQ_W-1 -: IFACE_W]];
    end
  end

  // First eligible requester at or after the round-robin pointer wins.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    gnt_next = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && out_free && eligible[(int'(rr_q) + k) % NUM_REQ]) begin
        found    = 1'b1;
        grant[(int'(rr_q) + k) % NUM_REQ] = 1'b1;
        gnt_idx  = PTR_W'((int'(rr_q) + k) % NUM_REQ);
        gnt_next = PTR_W'((int'(rr_q) + k + 1) % NUM_REQ);
      end
    end
  end

  assign sel       = req_arr[gnt_idx];
  assign sel_tag   = sel[TAG_W-1:0];
  assign issue     = found && present_q[sel_tag];
  assign drop      = found && !present_q[sel_tag];
  assign req_ready = reset ? '0 : grant;

  always_comb begin
    vld_d      = vld_q;
    vld_data_d = vld_data_q;
    rr_d       = rr_q;
    present_d  = present_q;
    drop_d     = drop_q;
    err_d      = err_q;
    if (found) rr_d = gnt_next;
    if (issue) begin
      vld_d      = 1'b1;
      vld_data_d = sel;
    end else if (tagstream_ready) begin
      vld_d = 1'b0;
    end
    if (drop) drop_d = sat_inc(drop_q);
    if (issue) present_d[sel_tag] = 1'b0;
    // The write-completion set is applied last so it wins over a same-cycle issue clear.
    if (wr_done) begin
      if (present_q[wr_tag] && !(issue && sel_tag == wr_tag)) err_d = 1'b1;
      present_d[wr_tag] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q      <= 1'b0;
      vld_data_q <= '0;
      rr_q       <= '0;
      present_q  <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      vld_data_q <= vld_data_d;
      rr_q       <= rr_d;
      present_q  <= present_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign tagstream_valid = vld_q;
  assign tagstream_data  = vld_data_q;
  assign drop_count      = drop_q;
  assign overwrite_err   = err_q;
endmodule
